// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO -> registered ALU wrapper -> result FIFO, strictly in order.
// Latency: push at edge T issues at T+1 and lands in the result FIFO at T+4 (no bypass).
// Backpressure: in_ready = command FIFO not full; issue is credit-gated so captures never overflow.

// Generic count-based FIFO.
// Zero-latency head: head_dat shows the oldest entry whenever count > 0.
// No internal protection: caller must never push when full nor pop when empty.
module alu_cmd_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;

  // Pointer increment with explicit wrap so non-power-of-2 depths work.
  always_comb begin
    wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
  end

  // Storage is not reset: validity is defined solely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers and occupancy; full/empty derive from count, never pointer equality.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr_nxt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

module alu_cmd_queue #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3:0]                    in_a,
  input  logic [3:0]                    in_b,
  input  logic [2:0]                    in_op,
  output logic [3:0]                    alu_a,
  output logic [3:0]                    alu_b,
  output logic [2:0]                    alu_op,
  input  logic [3:0]                    alu_result,
  input  logic                          alu_carry,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    out_result,
  output logic                          out_carry,
  output logic [$clog2(IN_DEPTH+1)-1:0] in_level
);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  typedef struct packed {
    logic [3:0] result;
    logic       carry;
  } res_t;

  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  // Wide enough for out_count plus three in-flight slots.
  localparam int CRW = $clog2(OUT_DEPTH + 4) + 1;

  cmd_t           cmd_in;
  cmd_t           cmd_head;
  logic           cmd_push;
  logic           cmd_empty;
  logic [ICW-1:0] cmd_cnt;

  res_t           res_in;
  res_t           res_head;
  logic           res_push;
  logic           res_pop;
  logic           res_empty;
  logic [OCW-1:0] res_cnt;

  logic           issue;
  logic           v0;
  logic           v1;
  logic           v2;
  logic [CRW-1:0] credit_used;
  logic           credit_ok;

  // ---------------------------------------------------------------------------
  // Command side
  // ---------------------------------------------------------------------------
  assign cmd_in   = '{a: in_a, b: in_b, op: in_op};
  // in_ready looks only at registered occupancy, never at out_ready.
  assign in_ready = (cmd_cnt != ICW'(IN_DEPTH));
  assign cmd_push = in_valid & in_ready;
  assign in_level = cmd_cnt;

  alu_cmd_queue_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (IN_DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_push),
    .push_dat (cmd_in),
    .pop      (issue),
    .head_dat (cmd_head),
    .count    (cmd_cnt),
    .empty    (cmd_empty)
  );

  // ---------------------------------------------------------------------------
  // Credit check: every issued command owns a result slot until it is popped.
  // Slots owned = buffered results + commands still inside the ALU pipe.
  // A pop this edge frees a slot in time for an issue on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_used = CRW'(res_cnt) + CRW'(v0) + CRW'(v1) + CRW'(v2);
    credit_ok   = (credit_used - CRW'(res_pop)) < CRW'(OUT_DEPTH);
    issue       = ~cmd_empty & credit_ok;
  end

  // Operand registers feeding the wrapper; they hold their value when idle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (issue) begin
      alu_a  <= cmd_head.a;
      alu_b  <= cmd_head.b;
      alu_op <= cmd_head.op;
    end
  end

  // Valid pipe shadowing the wrapper's two register stages.
  // v0: operands in alu_* are captured by the wrapper next edge.
  // v1: wrapper result register loads next edge.
  // v2: alu_result/alu_carry are valid this cycle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v0 <= issue;
      v1 <= v0;
      v2 <= v1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result side: the wrapper cannot stall, so capture is unconditional on v2.
  // ---------------------------------------------------------------------------
  assign res_in   = '{result: alu_result, carry: alu_carry};
  assign res_push = v2;
  assign res_pop  = out_valid & out_ready;

  alu_cmd_queue_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (OUT_DEPTH)
  ) u_res_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (res_push),
    .push_dat (res_in),
    .pop      (res_pop),
    .head_dat (res_head),
    .count    (res_cnt),
    .empty    (res_empty)
  );

  // Head is forced to zero while empty so the unreset storage never leaks out.
  always_comb begin
    out_valid  = ~res_empty;
    out_result = '0;
    out_carry  = 1'b0;
    if (out_valid) begin
      out_result = res_head.result;
      out_carry  = res_head.carry;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a behavioural model of the 2-stage ALU wrapper.
module tb_alu_cmd_queue;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic       out_carry;
  logic [2:0] in_level;

  int n_cmp = 0;
  int n_err = 0;
  int p;
  int k;
  int first;
  logic acc;

  // Back-to-back stream: add, sub, and, or, xor, not, shl, shr.
  logic [3:0] t3a [8] = '{4'h7, 4'h2, 4'hC, 4'h5, 4'hF, 4'h6, 4'h3, 4'h8};
  logic [3:0] t3b [8] = '{4'h9, 4'h7, 4'hA, 4'h2, 4'h3, 4'h0, 4'h1, 4'h3};
  logic [2:0] t3o [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [3:0] t3r [8] = '{4'h0, 4'hB, 4'h8, 4'h7, 4'hC, 4'h9, 4'h6, 4'h1};
  logic       t3c [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Back-pressure stream of 12.
  logic [3:0] t4a [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
  logic [3:0] t4b [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h1, 4'h1, 4'h9, 4'h3, 4'h6, 4'h4};
  logic [2:0] t4o [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [3:0] t4r [12] = '{4'h1, 4'hF, 4'h2, 4'h7, 4'h1, 4'hA, 4'hC, 4'h3, 4'h1, 4'h6, 4'h2, 4'hF};
  logic       t4c [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  alu_cmd_queue #(
    .IN_DEPTH  (4),
    .OUT_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .in_level   (in_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wrapper model: operand register stage, then result register stage.
  function automatic logic [4:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    s = '0;
    case (op)
      3'd0: s = {1'b0, a} + {1'b0, b};
      3'd1: begin s[3:0] = a - b; s[4] = (a < b); end
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      3'd4: s = {1'b0, a ^ b};
      3'd5: s = {1'b0, ~a};
      3'd6: s = {1'b0, a << b};
      default: s = {1'b0, a >> b};
    endcase
    return s;
  endfunction

  logic [3:0] wa;
  logic [3:0] wb;
  logic [2:0] wop;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wa         <= '0;
      wb         <= '0;
      wop        <= '0;
      alu_result <= '0;
      alu_carry  <= 1'b0;
    end else begin
      wa  <= alu_a;
      wb  <= alu_b;
      wop <= alu_op;
      {alu_carry, alu_result} <= alu_ref(wa, wb, wop);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    while (!ok && n < 50) begin
      ok = in_ready;
      step();
      n++;
    end
    in_valid = 1'b0;
    check("push_accept", ok, 1);
  endtask

  task automatic get_result(input string tag, input logic [3:0] r, input logic c);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, out_result, r);
    check({tag, "_carry"}, out_carry, c);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_in_level", in_level, 0);
    check("rst_out_result", out_result, 0);
    check("rst_alu_a", alu_a, 0);
    rst_n = 1'b0;
    step();

    // Single add with exact latency: 9 + 8 = 17
    push_one(4'h9, 4'h8, 3'd0);
    check("t1_level_after_push", in_level, 1);
    step();
    check("t1_alu_a", alu_a, 4'h9);
    check("t1_alu_b", alu_b, 4'h8);
    check("t1_alu_op", alu_op, 0);
    check("t1_level_after_issue", in_level, 0);
    step();
    step();
    check("t1_not_yet_valid", out_valid, 0);
    step();
    check("t1_valid", out_valid, 1);
    check("t1_result", out_result, 4'h1);
    check("t1_carry", out_carry, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t1_drained", out_valid, 0);

    // Sub with borrow, shift left, shift right
    push_one(4'h3, 4'h5, 3'd1);
    push_one(4'h1, 4'h2, 3'd6);
    push_one(4'hC, 4'h1, 3'd7);
    get_result("t2_sub", 4'hE, 1'b1);
    get_result("t2_shl", 4'h4, 1'b0);
    get_result("t2_shr", 4'h6, 1'b0);

    // Back-to-back throughput with out_ready held high
    out_ready = 1'b1;
    k = 0;
    first = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        in_a = t3a[c];
        in_b = t3b[c];
        in_op = t3o[c];
        check("t3_in_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid && k < 8) begin
        check($sformatf("t3_result%0d", k), out_result, t3r[k]);
        check($sformatf("t3_carry%0d", k), out_carry, t3c[k]);
        if (k == 0) first = c;
        else check($sformatf("t3_cycle%0d", k), c, first + k);
        k++;
      end
      step();
    end
    out_ready = 1'b0;
    check("t3_count", k, 8);

    // Back-pressure: out_ready low, stream 12
    p = 0;
    for (int c = 0; c < 16; c++) begin
      in_valid = (p < 12);
      if (p < 12) begin
        in_a = t4a[p];
        in_b = t4b[p];
        in_op = t4o[p];
      end
      acc = in_valid && in_ready;
      step();
      if (acc) p++;
    end
    check("t4_accepted", p, 8);
    check("t4_level_full", in_level, 4);
    check("t4_in_ready_low", in_ready, 0);
    check("t4_out_valid", out_valid, 1);
    check("t4_head_result", out_result, t4r[0]);
    check("t4_last_issue_a", alu_a, 4'h3);
    check("t4_last_issue_b", alu_b, 4'h4);
    check("t4_last_issue_op", alu_op, 3);

    // Release the consumer: remaining pushes go in, all 12 come out in order
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 80 && k < 12; c++) begin
      in_valid = (p < 12);
      if (p < 12) begin
        in_a = t4a[p];
        in_b = t4b[p];
        in_op = t4o[p];
      end
      acc = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("t4_result%0d", k), out_result, t4r[k]);
        check($sformatf("t4_carry%0d", k), out_carry, t4c[k]);
        k++;
      end
      step();
      if (acc) p++;
    end
    in_valid = 1'b0;
    check("t4_delivered", k, 12);
    for (int c = 0; c < 6; c++) step();
    check("t4_no_extra", out_valid, 0);
    check("t4_level_empty", in_level, 0);
    out_ready = 1'b0;

    // Reset with work in flight and both FIFOs partly full
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_a = 4'(c + 1);
      in_b = 4'h1;
      in_op = 3'd0;
      step();
    end
    in_valid = 1'b0;
    check("t5_pre_out_valid", out_valid, 1);
    check("t5_pre_level", in_level, 1);
    rst_n = 1'b1;
    step();
    check("t5_out_valid", out_valid, 0);
    check("t5_in_level", in_level, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_alu_a", alu_a, 0);
    check("t5_alu_b", alu_b, 0);
    check("t5_alu_op", alu_op, 0);
    rst_n = 1'b0;
    step();
    push_one(4'h2, 4'h2, 3'd0);
    get_result("t5_fresh", 4'h4, 1'b0);
    for (int c = 0; c < 8; c++) step();
    check("t5_no_stale", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
